stopwatch_ctrl: RTL and testbench

//   Sequencing controller for the stopwatch BCD digit chain (cascaded 4-bit decade counters).

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_tick_prescaler.sv | 33 +++
 rtl/stopwatch_ctrl.sv | 139 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and timebase divider helper for the stopwatch controller
package stopwatch_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        FULL  = 3'd4
    } state_t;

    // Clock cycles per least-significant-digit count; callers guarantee an exact integer >= 2.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// rtl/stopwatch_ctrl_tick_prescaler.sv - divide-by-DIV timebase producing one registered tick per wrap
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic Reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count while run is high, hold otherwise so a resume keeps its phase; tick marks each wrap.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/lap/clear sequencer; STOPWATCH_AUTO_STOP_EN adds the FULL stop-on-overflow state
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               btn_start_stop,
    input  logic               btn_lap_reset,
    input  logic               overflow_in,
    output logic               count_en,
    output logic               count_clr,
    output logic               display_freeze,
    output logic               running,
    output logic [STATE_W-1:0] state_o
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    state_t                 state;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic                   ss_last;
    logic                   lr_last;
    logic                   ss_p;
    logic                   lr_p;
    logic                   counting;
    logic                   stop_req;

    // Synchronize both buttons and remember the previous level; preset high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ss_sync <= '1;
            lr_sync <= '1;
            ss_last <= 1'b1;
            lr_last <= 1'b1;
        end else begin
            ss_sync <= {ss_sync[SYNC_STAGES-2:0], btn_start_stop};
            lr_sync <= {lr_sync[SYNC_STAGES-2:0], btn_lap_reset};
            ss_last <= ss_sync[SYNC_STAGES-1];
            lr_last <= lr_sync[SYNC_STAGES-1];
        end
    end

    // Start/stop has priority: a lap/reset press arriving in the same cycle is dropped.
    assign ss_p = ss_sync[SYNC_STAGES-1] & ~ss_last;
    assign lr_p = lr_sync[SYNC_STAGES-1] & ~lr_last & ~ss_p;

    assign counting = (state == RUN) || (state == LAP);

`ifdef STOPWATCH_AUTO_STOP_EN
    assign stop_req = overflow_in & counting;
`else
    logic unused_overflow;
    assign unused_overflow = overflow_in;
    assign stop_req        = 1'b0;
`endif

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .Reset (Reset),
        .run   (counting & ~stop_req),
        .clr   (state == IDLE),
        .tick  (count_en)
    );

    // Main sequencer with registered status/control outputs; an overflow stop outranks both buttons.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            count_clr      <= 1'b0;
            display_freeze <= 1'b0;
            running        <= 1'b0;
        end else begin
            count_clr <= 1'b0;
            if (stop_req) begin
                state          <= FULL;
                display_freeze <= 1'b0;
                running        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_p) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (ss_p) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (lr_p) begin
                            state          <= LAP;
                            display_freeze <= 1'b1;
                        end
                    end
                    LAP: begin
                        if (ss_p) begin
                            state          <= PAUSE;
                            display_freeze <= 1'b0;
                            running        <= 1'b0;
                        end else if (lr_p) begin
                            state          <= RUN;
                            display_freeze <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (ss_p) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else if (lr_p) begin
                            state     <= IDLE;
                            count_clr <= 1'b1;
                        end
                    end
                    FULL: begin
                        if (lr_p) begin
                            state     <= IDLE;
                            count_clr <= 1'b1;
                        end
                    end
                    default: begin
                        state          <= IDLE;
                        display_freeze <= 1'b0;
                        running        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl (DIV=10, 2 sync stages)
module tb_stopwatch_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_LAP   = 3'd3;
    localparam logic [2:0] ST_FULL  = 3'd4;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       btn_start_stop = 1'b0;
    logic       btn_lap_reset = 1'b0;
    logic       overflow_in = 1'b0;
    logic       count_en;
    logic       count_clr;
    logic       display_freeze;
    logic       running;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .btn_start_stop (btn_start_stop),
        .btn_lap_reset  (btn_lap_reset),
        .overflow_in    (overflow_in),
        .count_en       (count_en),
        .count_clr      (count_clr),
        .display_freeze (display_freeze),
        .running        (running),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset          = 1'b1;
        btn_start_stop = 1'b0;
        btn_lap_reset  = 1'b0;
        overflow_in    = 1'b0;
        step(2);
        Reset = 1'b0;
    endtask

    // Press driven after edge E takes effect at edge E+3.
    task automatic press_ss();
        btn_start_stop = 1'b1;
        step(3);
        btn_start_stop = 1'b0;
    endtask

    task automatic press_lr();
        btn_lap_reset = 1'b1;
        step(3);
        btn_lap_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] seen;
        apply_reset();
        seen = '0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            seen = seen | {count_en, count_clr, display_freeze, running, state_o};
        end
        checks++;
        if (seen !== 7'd0) begin
            errors++;
            $display("FAIL reset_idle: outputs or-ed %b expected 0000000", seen);
        end
        checks++;
        if (state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", state_o, ST_IDLE);
        end
    endtask

    task automatic test_run();
        int   pulses;
        logic exp;
        pulses = 0;
        apply_reset();
        step(1);
        btn_start_stop = 1'b1;
        step(2);
        checks++;
        if (state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL start_latency: got %0d expected %0d", state_o, ST_IDLE);
        end
        step(1);
        btn_start_stop = 1'b0;
        checks++;
        if (state_o !== ST_RUN) begin
            errors++;
            $display("FAIL run_state: got %0d expected %0d", state_o, ST_RUN);
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL run_running: got %b expected 1", running);
        end
        for (int k = 1; k <= 105; k++) begin
            step(1);
            exp = (k % 10 == 0);
            checks++;
            if (count_en !== exp) begin
                errors++;
                $display("FAIL run_count_en cycle %0d: got %b expected %b", k, count_en, exp);
            end
            if (count_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL run_pulse_total: got %0d expected 10", pulses);
        end
    endtask

    task automatic test_pause_resume();
        logic seen;
        logic exp;
        apply_reset();
        step(1);
        press_ss();
        step(1);
        press_ss();
        checks++;
        if (state_o !== ST_PAUSE || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_state: got state %0d running %b expected %0d 0", state_o, running, ST_PAUSE);
        end
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            seen = seen | count_en;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL pause_count_en: got %b expected 0", seen);
        end
        press_ss();
        checks++;
        if (state_o !== ST_RUN) begin
            errors++;
            $display("FAIL resume_state: got %0d expected %0d", state_o, ST_RUN);
        end
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp = (k == 6) || (k == 16);
            checks++;
            if (count_en !== exp) begin
                errors++;
                $display("FAIL resume_phase cycle %0d: got %b expected %b", k, count_en, exp);
            end
        end
    endtask

    task automatic test_lap();
        logic exp;
        apply_reset();
        step(1);
        press_ss();
        step(1);
        press_lr();
        checks++;
        if (state_o !== ST_LAP || display_freeze !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL lap_enter: got state %0d freeze %b running %b expected %0d 1 1",
                     state_o, display_freeze, running, ST_LAP);
        end
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp = ((4 + k) % 10 == 0);
            checks++;
            if (count_en !== exp) begin
                errors++;
                $display("FAIL lap_count_en cycle %0d: got %b expected %b", k, count_en, exp);
            end
        end
        step(1);
        btn_lap_reset = 1'b1;
        step(2);
        checks++;
        if (display_freeze !== 1'b1) begin
            errors++;
            $display("FAIL lap_exit_latency: got %b expected 1", display_freeze);
        end
        step(1);
        btn_lap_reset = 1'b0;
        checks++;
        if (state_o !== ST_RUN || display_freeze !== 1'b0) begin
            errors++;
            $display("FAIL lap_exit: got state %0d freeze %b expected %0d 0", state_o, display_freeze, ST_RUN);
        end
    endtask

    task automatic test_clear_and_priority();
        apply_reset();
        step(1);
        press_lr();
        checks++;
        if (state_o !== ST_IDLE || count_clr !== 1'b0) begin
            errors++;
            $display("FAIL idle_lap_ignored: got state %0d clr %b expected %0d 0", state_o, count_clr, ST_IDLE);
        end
        step(1);
        press_ss();
        step(1);
        press_ss();
        step(1);
        btn_lap_reset = 1'b1;
        step(2);
        checks++;
        if (state_o !== ST_PAUSE || count_clr !== 1'b0) begin
            errors++;
            $display("FAIL clear_latency: got state %0d clr %b expected %0d 0", state_o, count_clr, ST_PAUSE);
        end
        step(1);
        btn_lap_reset = 1'b0;
        checks++;
        if (state_o !== ST_IDLE || count_clr !== 1'b1) begin
            errors++;
            $display("FAIL clear_pulse: got state %0d clr %b expected %0d 1", state_o, count_clr, ST_IDLE);
        end
        step(1);
        checks++;
        if (count_clr !== 1'b0) begin
            errors++;
            $display("FAIL clear_width: got %b expected 0", count_clr);
        end
        press_ss();
        step(1);
        btn_start_stop = 1'b1;
        btn_lap_reset  = 1'b1;
        step(3);
        btn_start_stop = 1'b0;
        btn_lap_reset  = 1'b0;
        checks++;
        if (state_o !== ST_PAUSE || display_freeze !== 1'b0 || count_clr !== 1'b0) begin
            errors++;
            $display("FAIL both_buttons: got state %0d freeze %b clr %b expected %0d 0 0",
                     state_o, display_freeze, count_clr, ST_PAUSE);
        end
    endtask

    task automatic test_overflow();
        logic seen;
        logic exp;
        apply_reset();
        step(1);
        press_ss();
        step(1);
        overflow_in = 1'b1;
        step(1);
        overflow_in = 1'b0;
`ifdef STOPWATCH_AUTO_STOP_EN
        checks++;
        if (state_o !== ST_FULL || running !== 1'b0 || display_freeze !== 1'b0) begin
            errors++;
            $display("FAIL full_enter: got state %0d running %b expected %0d 0", state_o, running, ST_FULL);
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            seen = seen | count_en;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL full_count_en: got %b expected 0", seen);
        end
        press_ss();
        checks++;
        if (state_o !== ST_FULL) begin
            errors++;
            $display("FAIL full_start_ignored: got %0d expected %0d", state_o, ST_FULL);
        end
        step(1);
        press_lr();
        checks++;
        if (state_o !== ST_IDLE || count_clr !== 1'b1) begin
            errors++;
            $display("FAIL full_clear: got state %0d clr %b expected %0d 1", state_o, count_clr, ST_IDLE);
        end
        exp = 1'b0;
`else
        seen = 1'b0;
        checks++;
        if (state_o !== ST_RUN) begin
            errors++;
            $display("FAIL overflow_ignored: got %0d expected %0d", state_o, ST_RUN);
        end
        for (int k = 1; k <= 18; k++) begin
            step(1);
            exp = (k == 8) || (k == 18);
            checks++;
            if (count_en !== exp) begin
                errors++;
                $display("FAIL overflow_count_en cycle %0d: got %b expected %b", k, count_en, exp);
            end
            seen = seen | count_en;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL overflow_counting: got %b expected 1", seen);
        end
`endif
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1);
        press_ss();
        step(5);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (state_o !== ST_IDLE || running !== 1'b0 || count_en !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got state %0d running %b count_en %b expected %0d 0 0",
                     state_o, running, count_en, ST_IDLE);
        end
        step(1);
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause_resume();
        test_lap();
        test_clear_and_priority();
        test_overflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
